// File: rtl/exhaustive_vector_sequencer_pkg.sv
// Shared types and helpers for the exhaustive vector sequencer.
// Covers state and order encodings, the Gray mapping and the MISR step.
package seq_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} seq_state_t;
  typedef enum logic {ORD_BIN, ORD_GRAY} seq_order_t;

  localparam int SIG_MAX = 32;

  function automatic logic [16:0] gray(input logic [16:0] v);
    return v ^ (v >> 1);
  endfunction

  // One MISR step at width w (<= SIG_MAX): shift left, parity of tapped bits into bit 0, xor response.
  function automatic logic [SIG_MAX-1:0] misr_next(input logic [SIG_MAX-1:0] sig,
                                                   input logic [SIG_MAX-1:0] poly,
                                                   input logic [SIG_MAX-1:0] resp,
                                                   input int unsigned w);
    logic [SIG_MAX-1:0] mask;
    logic               fb;
    mask = (w >= SIG_MAX) ? '1 : ((SIG_MAX'(1) << w) - SIG_MAX'(1));
    fb   = ^(sig & poly & mask);
    return (((sig << 1) | SIG_MAX'(fb)) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/exhaustive_vector_sequencer_fifo.sv
// Synchronous record FIFO; head appears one cycle after the first push.
// A push into a full FIFO is accepted when the head is popped in the same cycle.
module vec_rec_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  output logic         push_ok_o,
  input  logic         pop_rdy_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop, do_push;

  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_q];
  assign pop        = head_vld_o && pop_rdy_i;
  assign push_ok_o  = (cnt_q != (AW+1)'(DEPTH)) || pop;
  assign do_push    = push_i && push_ok_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps all 2^N_IN vectors into a combinational DUT (binary or Gray order), 2+SETTLE cycles each,
// streaming {vector,response} records through a ready/valid FIFO; a full FIFO stalls capture.
module exhaustive_vector_sequencer
  import seq_pkg::*;
#(
  parameter int               N_IN     = 3,
  parameter int               N_OUT    = 1,
  parameter int               SETTLE   = 1,
  parameter int               DEPTH    = 4,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h8016,
  parameter logic [SIG_W-1:0] SIG_SEED = '1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic [N_IN-1:0]       dut_in,
  input  logic [N_OUT-1:0]      dut_out,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [N_IN+N_OUT-1:0] rec_data,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_W-1:0]      signature
);

  localparam int RW   = N_IN + N_OUT;
  localparam int SC_W = $clog2(SETTLE + 2);

  seq_state_t       state_q;
  seq_order_t       order_q;
  logic [N_IN:0]    idx_q;
  logic [SC_W-1:0]  settle_q;
  logic [N_IN-1:0]  dut_in_q, vec_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             busy_q, done_q;
  logic             cap, push_ok, push, start_ok, last;

  assign cap      = (state_q == CAPTURE);
  assign push     = cap && push_ok;
  assign start_ok = start && ((state_q == IDLE) || ((state_q == DONE) && !rec_valid));
  assign last     = (idx_q[N_IN-1:0] == {N_IN{1'b1}});

  always_comb begin
    vec_d = N_IN'(idx_q);
    if (order_q == ORD_GRAY) vec_d = N_IN'(gray(17'(idx_q)));
    sig_d = SIG_W'(misr_next(SIG_MAX'(sig_q), SIG_MAX'(SIG_POLY), SIG_MAX'(dut_out), SIG_W));
  end

  vec_rec_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (CK),
    .rst_ni     (reset),
    .push_i     (cap),
    .push_dat_i ({dut_in_q, dut_out}),
    .push_ok_o  (push_ok),
    .pop_rdy_i  (rec_ready),
    .head_vld_o (rec_valid),
    .head_dat_o (rec_data)
  );

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      order_q  <= ORD_BIN;
      idx_q    <= '0;
      settle_q <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= SIG_SEED;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            idx_q   <= '0;
            order_q <= seq_order_t'(mode);
            sig_q   <= SIG_SEED;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          dut_in_q <= vec_d;
          settle_q <= '0;
          state_q  <= (SETTLE == 0) ? CAPTURE : seq_pkg::SETTLE;
        end
        seq_pkg::SETTLE: begin
          if (settle_q == SC_W'(SETTLE - 1)) state_q <= CAPTURE;
          else settle_q <= settle_q + SC_W'(1);
        end
        CAPTURE: begin
          // Without a push slot we simply stay here, holding dut_in and resampling.
          if (push) begin
            sig_q <= sig_d;
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + (N_IN+1)'(1);
              state_q <= APPLY;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench: u0 (SETTLE=1, DUT=&dut_in) covers order, stall, reset and restart;
// u1 (SETTLE=0, DUT=^dut_in) covers the zero-settle sweep.
module tb_exhaustive_vector_sequencer;

  logic        CK = 1'b0;
  logic        reset = 1'b1;
  always #5 CK = ~CK;

  logic        start0, mode0, rec_ready0, rec_valid0, busy0, done0;
  logic [2:0]  dut_in0;
  logic [0:0]  dut_out0;
  logic [3:0]  rec_data0;
  logic [15:0] sig0;
  logic        start1, mode1, rec_ready1, rec_valid1, busy1, done1;
  logic [2:0]  dut_in1;
  logic [0:0]  dut_out1;
  logic [3:0]  rec_data1;
  logic [15:0] sig1;

  assign dut_out0 = &dut_in0;
  assign dut_out1 = ^dut_in1;

  exhaustive_vector_sequencer #(.N_IN(3), .N_OUT(1), .SETTLE(1), .DEPTH(4), .SIG_W(16),
                                .SIG_POLY(16'h8016), .SIG_SEED(16'hFFFF)) u0 (
    .CK(CK), .reset(reset), .start(start0), .mode(mode0), .dut_in(dut_in0), .dut_out(dut_out0),
    .rec_valid(rec_valid0), .rec_ready(rec_ready0), .rec_data(rec_data0), .busy(busy0),
    .done(done0), .signature(sig0));

  exhaustive_vector_sequencer #(.N_IN(3), .N_OUT(1), .SETTLE(0), .DEPTH(4), .SIG_W(16),
                                .SIG_POLY(16'h8016), .SIG_SEED(16'hFFFF)) u1 (
    .CK(CK), .reset(reset), .start(start1), .mode(mode1), .dut_in(dut_in1), .dut_out(dut_out1),
    .rec_valid(rec_valid1), .rec_ready(rec_ready1), .rec_data(rec_data1), .busy(busy1),
    .done(done1), .signature(sig1));

  int checks = 0;
  int errors = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  // Records are accepted at the next rising edge; inputs only change just after rising edges.
  always @(negedge CK) begin
    if (rec_valid0 && rec_ready0) q0.push_back(rec_data0);
    if (rec_valid1 && rec_ready1) q1.push_back(rec_data1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    return {s[14:0], ^(s & 16'h8016)} ^ {15'b0, r};
  endfunction

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && n < 300) begin
      step();
      n++;
    end
  endtask

  // Hand tables: Gray order, and response bit per vector for & and ^ DUTs.
  logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic [7:0] and_tab = 8'b1000_0000;
  logic [7:0] xor_tab = 8'b1001_0110;

  task automatic check_sweep(input string tag, input int which, input int base, input bit gray_ord);
    logic [15:0] s;
    logic [3:0]  obs;
    logic [2:0]  v;
    logic        r;
    s = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      v   = gray_ord ? gtab[i] : 3'(i);
      r   = (which == 0) ? and_tab[v] : xor_tab[v];
      obs = 4'bxxxx;
      if (which == 0 && base + i < q0.size()) obs = q0[base + i];
      if (which == 1 && base + i < q1.size()) obs = q1[base + i];
      chk($sformatf("%s_rec%0d", tag, i), 32'(obs), 32'({v, r}));
      s = misr_step(s, r);
    end
    chk({tag, "_nrec"}, (which == 0) ? q0.size() : q1.size(), base + 8);
    chk({tag, "_sig"}, (which == 0) ? sig0 : sig1, s);
  endtask

  initial begin
    int n, m;
    start0 = 0; mode0 = 0; rec_ready0 = 1;
    start1 = 0; mode1 = 0; rec_ready1 = 1;
    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_dut_in", dut_in0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid", rec_valid0, 0);
    chk("rst_sig", sig0, 16'hFFFF);
    chk("rst_sig1", sig1, 16'hFFFF);
    reset = 1'b1;
    step();

    // 1: binary sweep with free-running consumer
    q0.delete();
    start0 = 1; step(); start0 = 0;
    wait_done(0, n);
    chk("t1_done_lat", n, 24);
    chk("t1_busy_after", busy0, 0);
    chk("t1_dut_in_held", dut_in0, 3'b111);
    step(); step();
    chk("t1_drained", rec_valid0, 0);
    check_sweep("t1", 0, 0, 0);

    // 2: Gray sweep; mode toggled mid-sweep must not matter
    q0.delete();
    mode0 = 1;
    start0 = 1; step(); start0 = 0;
    repeat (5) step();
    mode0 = 0;
    wait_done(0, n);
    chk("t2_done_lat", n + 5, 24);
    chk("t2_dut_in_held", dut_in0, 3'b100);
    step(); step();
    check_sweep("t2", 0, 0, 1);

    // 3: consumer blocked -> FIFO fills, sequencer stalls on vector 100
    q0.delete();
    rec_ready0 = 0;
    start0 = 1; step(); start0 = 0;
    repeat (40) step();
    chk("t3_no_pops", q0.size(), 0);
    chk("t3_valid", rec_valid0, 1);
    chk("t3_head_held", rec_data0, 4'b0000);
    chk("t3_stall_vec", dut_in0, 3'b100);
    chk("t3_busy", busy0, 1);
    chk("t3_no_done", done0, 0);
    start0 = 1; step(); start0 = 0;
    rec_ready0 = 1;
    wait_done(0, n);
    chk("t3_done_seen", done0, 1);
    repeat (3) step();
    check_sweep("t3", 0, 0, 0);

    // 4: reset in the middle of a sweep
    q0.delete();
    start0 = 1; step(); start0 = 0;
    n = 0;
    while (dut_in0 !== 3'd5 && n < 100) begin step(); n++; end
    chk("t4_reached_5", dut_in0, 3'd5);
    reset = 1'b0;
    #1;
    chk("t4_rst_dut_in", dut_in0, 0);
    chk("t4_rst_busy", busy0, 0);
    chk("t4_rst_done", done0, 0);
    chk("t4_rst_valid", rec_valid0, 0);
    chk("t4_rst_sig", sig0, 16'hFFFF);
    step();
    reset = 1'b1;
    step();
    q0.delete();
    start0 = 1; step(); start0 = 0;
    wait_done(0, n);
    chk("t4_done_lat", n, 24);
    step(); step();
    check_sweep("t4", 0, 0, 0);

    // 5: start held high -> one sweep, restart only once FIFO drained in DONE
    q0.delete();
    start0 = 1;
    step();
    wait_done(0, n);
    chk("t5_done_lat1", n, 24);
    m = 0;
    while (done0 === 1'b1 && m < 10) begin step(); m++; end
    chk("t5_done_width", m, 2);
    chk("t5_restart_busy", busy0, 1);
    wait_done(0, n);
    chk("t5_done_lat2", n, 24);
    start0 = 0;
    step(); step();
    check_sweep("t5b", 0, 8, 0);

    // 6: zero settle, XOR DUT
    q1.delete();
    start1 = 1; step(); start1 = 0;
    wait_done(1, n);
    chk("t6_done_lat", n, 16);
    chk("t6_dut_in_held", dut_in1, 3'b111);
    chk("t6_busy_after", busy1, 0);
    step(); step();
    check_sweep("t6", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
